// File: rtl/stream_out_fifo_pkg.sv
// Shared types and defaults for the stream output FIFO.
package stream_out_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } frame_state_e;

  localparam int FRAME_LEN_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x W register array with one synchronous write port and an asynchronous read port.
module sync_fifo_mem #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  // Storage is intentionally not reset; the head is qualified by occupancy upstream.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_out_fifo.sv
// Frame-aware output FIFO between the stream controller and an AXI-Stream DMA master port.
// state  | meaning
// IDLE   | no frame in progress, FIFO empty of framed data
// ACTIVE | frame being pushed, last word not yet seen
// DRAIN  | last word pushed, upstream held off until it pops
module stream_out_fifo
  import stream_out_fifo_pkg::*;
#(
  parameter int DW        = 32,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [DW-1:0]            in_data_i,
  input  logic                     in_last_i,
  output logic                     in_ready_o,
  output logic                     m_axis_tvalid_o,
  output logic [DW-1:0]            m_axis_tdata_o,
  output logic                     m_axis_tlast_o,
  input  logic                     m_axis_tready_i,
  output logic                     frame_done_o,
  output logic                     len_err_o,
  output logic [$clog2(DEPTH):0]   word_cnt_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FRAME_LEN + 1) + 1;

  frame_state_e   state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [FCW-1:0] fcnt_inc;
  logic           len_err_q, len_err_d;
  logic           done_q, done_d;
  logic           push, pop;
  logic [DW:0]    head;

  sync_fifo_mem #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_last_i, in_data_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign in_ready_o      = (cnt_q < CW'(DEPTH)) && (state_q != DRAIN);
  assign m_axis_tvalid_o = (cnt_q != '0);
  assign m_axis_tdata_o  = head[DW-1:0];
  assign m_axis_tlast_o  = head[DW] & m_axis_tvalid_o;
  assign frame_done_o    = done_q;
  assign len_err_o       = len_err_q;
  assign word_cnt_o      = cnt_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = m_axis_tvalid_o & m_axis_tready_i;

  // Saturating so an overlong frame can never wrap back onto FRAME_LEN.
  assign fcnt_inc = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    len_err_d = len_err_q;
    done_d    = pop & m_axis_tlast_o;
    state_d   = state_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (push) begin
      if (in_last_i) begin
        fcnt_d = '0;
        if (fcnt_inc != FCW'(FRAME_LEN)) len_err_d = 1'b1;
      end else begin
        fcnt_d = fcnt_inc;
      end
    end

    case (state_q)
      IDLE: begin
        if (push) state_d = in_last_i ? DRAIN : ACTIVE;
      end
      ACTIVE: begin
        if (push && in_last_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && m_axis_tlast_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_stream_out_fifo.sv
// Directed self-checking bench for stream_out_fifo (DW=32, DEPTH=8, FRAME_LEN=4).
module tb_stream_out_fifo;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_last_i;
  logic        in_ready_o;
  logic        m_axis_tvalid_o;
  logic [31:0] m_axis_tdata_o;
  logic        m_axis_tlast_o;
  logic        m_axis_tready_i;
  logic        frame_done_o;
  logic        len_err_o;
  logic [3:0]  word_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  stream_out_fifo #(.DW(32), .DEPTH(8), .FRAME_LEN(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_valid_i      (in_valid_i),
    .in_data_i       (in_data_i),
    .in_last_i       (in_last_i),
    .in_ready_o      (in_ready_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tready_i (m_axis_tready_i),
    .frame_done_o    (frame_done_o),
    .len_err_o       (len_err_o),
    .word_cnt_o      (word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    bit pushed;
    pushed     = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    for (int i = 0; i < 20; i++) begin
      if (in_ready_o) begin
        step();
        pushed = 1'b1;
        break;
      end
      step();
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    chk("push_accepted", 64'(pushed), 64'd1);
  endtask

  task automatic expect_pop(input string tag, input logic [31:0] d, input logic last);
    bit seen;
    seen            = 1'b0;
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_axis_tvalid_o) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_tvalid"}, 64'(seen), 64'd1);
    chk({tag, "_tdata"}, 64'(m_axis_tdata_o), 64'(d));
    chk({tag, "_tlast"}, 64'(m_axis_tlast_o), 64'(last));
    step();
    m_axis_tready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] nxt;
    logic [31:0] word;
    int          pops;
    bit          r;

    rst_ni          = 1'b0;
    in_valid_i      = 1'b0;
    in_data_i       = '0;
    in_last_i       = 1'b0;
    m_axis_tready_i = 1'b0;

    // Reset values
    #2;
    chk("rst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast_o), 64'd0);
    chk("rst_cnt", 64'(word_cnt_o), 64'd0);
    chk("rst_done", 64'(frame_done_o), 64'd0);
    chk("rst_len_err", 64'(len_err_o), 64'd0);
    #10 rst_ni = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Single frame with tready=1
    m_axis_tready_i = 1'b1;
    in_valid_i = 1'b1; in_data_i = 32'hA000_0000; in_last_i = 1'b0;
    chk("a0_no_early_valid", 64'(m_axis_tvalid_o), 64'd0);
    step();
    chk("a0_tvalid", 64'(m_axis_tvalid_o), 64'd1);
    chk("a0_tdata", 64'(m_axis_tdata_o), 64'hA000_0000);
    chk("a0_cnt", 64'(word_cnt_o), 64'd1);
    chk("a0_tlast", 64'(m_axis_tlast_o), 64'd0);
    in_data_i = 32'hA000_0001;
    step();
    chk("a1_tdata", 64'(m_axis_tdata_o), 64'hA000_0001);
    chk("a1_cnt", 64'(word_cnt_o), 64'd1);
    in_data_i = 32'hA000_0002;
    step();
    chk("a2_tdata", 64'(m_axis_tdata_o), 64'hA000_0002);
    chk("a2_tlast", 64'(m_axis_tlast_o), 64'd0);
    in_data_i = 32'hA000_0003; in_last_i = 1'b1;
    step();
    in_valid_i = 1'b0; in_last_i = 1'b0;
    chk("a3_tdata", 64'(m_axis_tdata_o), 64'hA000_0003);
    chk("a3_tlast", 64'(m_axis_tlast_o), 64'd1);
    chk("a3_drain_ready", 64'(in_ready_o), 64'd0);
    chk("a3_no_done_yet", 64'(frame_done_o), 64'd0);
    step();
    chk("a_done", 64'(frame_done_o), 64'd1);
    chk("a_empty", 64'(m_axis_tvalid_o), 64'd0);
    chk("a_ready", 64'(in_ready_o), 64'd1);
    step();
    chk("a_done_once", 64'(frame_done_o), 64'd0);
    chk("a_len_err", 64'(len_err_o), 64'd0);
    m_axis_tready_i = 1'b0;

    // DRAIN blocks the next frame until the last word pops
    for (int k = 0; k < 4; k++) push_word(32'hC000_0000 + 32'(k), k == 3);
    chk("c_cnt", 64'(word_cnt_o), 64'd4);
    chk("c_drain_ready", 64'(in_ready_o), 64'd0);
    in_valid_i = 1'b1; in_data_i = 32'hB000_0000; in_last_i = 1'b0;
    step();
    step();
    chk("c_b0_blocked_cnt", 64'(word_cnt_o), 64'd4);
    chk("c_b0_blocked_ready", 64'(in_ready_o), 64'd0);
    chk("c_hold_tdata", 64'(m_axis_tdata_o), 64'hC000_0000);
    m_axis_tready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("c_pop_tdata", 64'(m_axis_tdata_o), 64'(32'hC000_0000 + 32'(k)));
      chk("c_pop_tlast", 64'(m_axis_tlast_o), 64'(k == 3));
      step();
    end
    m_axis_tready_i = 1'b0;
    chk("c_done", 64'(frame_done_o), 64'd1);
    chk("c_empty_cnt", 64'(word_cnt_o), 64'd0);
    chk("c_ready_again", 64'(in_ready_o), 64'd1);
    step();
    in_valid_i = 1'b0;
    chk("b0_pushed_cnt", 64'(word_cnt_o), 64'd1);
    chk("b0_tdata", 64'(m_axis_tdata_o), 64'hB000_0000);
    chk("b0_active_ready", 64'(in_ready_o), 64'd1);
    for (int k = 1; k < 4; k++) push_word(32'hB000_0000 + 32'(k), k == 3);
    for (int k = 0; k < 4; k++) expect_pop("b_pop", 32'hB000_0000 + 32'(k), k == 3);
    chk("b_done", 64'(frame_done_o), 64'd1);
    chk("b_len_err", 64'(len_err_o), 64'd0);

    // Simultaneous push/pop at occupancy 3 across pointer wrap
    for (int k = 0; k < 3; k++) begin
      push_word(32'hD000_0000 + 32'(k), 1'b0);
      q.push_back(32'hD000_0000 + 32'(k));
    end
    chk("d_cnt3", 64'(word_cnt_o), 64'd3);
    nxt  = 32'hD000_0003;
    pops = 0;
    for (int i = 0; i < 300 && pops < 20; i++) begin
      r = 1'($urandom_range(0, 1));
      in_valid_i      = r;
      in_data_i       = nxt;
      in_last_i       = 1'b0;
      m_axis_tready_i = r;
      if (r) begin
        chk("d_ready", 64'(in_ready_o), 64'd1);
        word = q.pop_front();
        chk("d_order", 64'(m_axis_tdata_o), 64'(word));
      end
      step();
      if (r) begin
        q.push_back(nxt);
        nxt++;
        pops++;
      end
      chk("d_cnt_steady", 64'(word_cnt_o), 64'd3);
    end
    in_valid_i = 1'b0; m_axis_tready_i = 1'b0;
    chk("d_enough_pops", 64'(pops >= 20), 64'd1);

    // Reset mid-frame after two pushes
    #1 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    step();
    q.delete();
    push_word(32'hE000_0000, 1'b0);
    push_word(32'hE000_0001, 1'b0);
    chk("e_cnt2", 64'(word_cnt_o), 64'd2);
    #1 rst_ni = 1'b0;
    #1;
    chk("e_rst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    chk("e_rst_cnt", 64'(word_cnt_o), 64'd0);
    chk("e_rst_ready", 64'(in_ready_o), 64'd1);
    #2 rst_ni = 1'b1;
    step();
    for (int k = 0; k < 4; k++) push_word(32'hF000_0000 + 32'(k), k == 3);
    chk("f_cnt", 64'(word_cnt_o), 64'd4);
    for (int k = 0; k < 4; k++) expect_pop("f_pop", 32'hF000_0000 + 32'(k), k == 3);
    chk("f_done", 64'(frame_done_o), 64'd1);
    chk("f_len_err", 64'(len_err_o), 64'd0);

    // Short frame sets a sticky length error
    for (int k = 0; k < 3; k++) push_word(32'h6000_0000 + 32'(k), k == 2);
    chk("g_len_err_set", 64'(len_err_o), 64'd1);
    for (int k = 0; k < 3; k++) expect_pop("g_pop", 32'h6000_0000 + 32'(k), k == 2);
    for (int k = 0; k < 4; k++) push_word(32'h7000_0000 + 32'(k), k == 3);
    for (int k = 0; k < 4; k++) expect_pop("h_pop", 32'h7000_0000 + 32'(k), k == 3);
    chk("h_len_err_sticky", 64'(len_err_o), 64'd1);

    // Backpressure fills the FIFO to DEPTH
    for (int k = 0; k < 8; k++) push_word(32'h8000_0000 + 32'(k), k == 7);
    chk("k_full_cnt", 64'(word_cnt_o), 64'd8);
    chk("k_full_ready", 64'(in_ready_o), 64'd0);
    step();
    chk("k_full_hold_cnt", 64'(word_cnt_o), 64'd8);
    for (int k = 0; k < 8; k++) expect_pop("k_pop", 32'h8000_0000 + 32'(k), k == 7);
    chk("k_done", 64'(frame_done_o), 64'd1);
    chk("k_empty_cnt", 64'(word_cnt_o), 64'd0);
    chk("k_ready_again", 64'(in_ready_o), 64'd1);
    chk("k_len_err_sticky", 64'(len_err_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
